// File: rtl/dm_access_ctrl_if.sv
// dm_access_ctrl_if
//   Data-memory bus between the MEM-stage access controller and the data memory.
//   master : controller side (drives request, strobe, lanes, address, write data)
//   slave  : memory side (returns read data and the completion handshake)
//   mem_en     request active
//   mem_we     write strobe
//   mem_be     byte-lane enables
//   mem_addr   word-aligned address
//   mem_wdata  lane-replicated store data
//   mem_rdata  read data from memory
//   mem_ready  memory completes the access this cycle
interface dm_access_ctrl_if;
   logic        mem_en;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ready;

   modport master (
      output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
      input  mem_rdata, mem_ready
   );

   modport slave (
      input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
      output mem_rdata, mem_ready
   );
endinterface

// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl
//   MEM-stage data-memory access controller. Accepts one load/store per
//   instruction, issues it on a variable-latency memory bus, stalls the
//   pipeline until completion, extends load data and flags misaligned
//   accesses and bus timeouts.
//   Parameters: TIMEOUT (1..255) max ACCESS cycles waiting for mem_ready.
//   Ports:
//     clk, reset            clock, async active-high reset
//     req_valid, req_we     request present, 1 = store
//     st_signal, ld_signed  size (00 byte, 01 half, 10 word), load sign-extend
//     addr, wdata           byte address, right-justified store data
//     stall                 freeze upstream pipeline (combinational)
//     rdata, done           extended load result, completion pulse
//     exc_valid, exc_code   exception pulse, 01 AdEL / 10 AdES / 11 timeout
//     mem                   memory bus (master modport)
module dm_access_ctrl #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     req_valid,
   input  logic                     req_we,
   input  logic [1:0]               st_signal,
   input  logic                     ld_signed,
   input  logic [31:0]              addr,
   input  logic [31:0]              wdata,
   output logic                     stall,
   output logic [31:0]              rdata,
   output logic                     done,
   output logic                     exc_valid,
   output logic [1:0]               exc_code,
   dm_access_ctrl_if.master         mem
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERR} state_e;

   localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

   state_e      state_q, state_d;
   logic [7:0]  wait_cnt_q, wait_cnt_d;
   logic        mem_en_q, mem_en_d;
   logic        mem_we_q, mem_we_d;
   logic [3:0]  mem_be_q, mem_be_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [1:0]  size_q, size_d;
   logic [1:0]  off_q, off_d;
   logic        ld_signed_q, ld_signed_d;
   logic        store_q, store_d;
   logic [31:0] rdata_q, rdata_d;
   logic        done_q, done_d;
   logic        exc_valid_q, exc_valid_d;
   logic [1:0]  exc_code_q, exc_code_d;

   logic        misaligned;
   logic [3:0]  be_req;
   logic [31:0] wdata_rep;
   logic [31:0] rd_shifted;
   logic [31:0] rd_ext;

   // Request decode: lane enables, store replication and alignment check.
   always_comb begin
      misaligned = 1'b0;
      be_req     = '0;
      wdata_rep  = wdata;
      case (st_signal)
         2'b00: begin
            be_req    = 4'b0001 << addr[1:0];
            wdata_rep = {4{wdata[7:0]}};
         end
         2'b01: begin
            misaligned = addr[0];
            be_req     = addr[1] ? 4'b1100 : 4'b0011;
            wdata_rep  = {2{wdata[15:0]}};
         end
         2'b10: begin
            misaligned = |addr[1:0];
            be_req     = 4'b1111;
         end
         default: misaligned = 1'b1;
      endcase
   end

   // Load extension: shift the addressed lane down to bit 0, then extend.
   always_comb begin
      rd_shifted = mem.mem_rdata >> {off_q, 3'b000};
      case (size_q)
         2'b00:   rd_ext = {{24{ld_signed_q & rd_shifted[7]}},  rd_shifted[7:0]};
         2'b01:   rd_ext = {{16{ld_signed_q & rd_shifted[15]}}, rd_shifted[15:0]};
         default: rd_ext = mem.mem_rdata;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      mem_en_d    = mem_en_q;
      mem_we_d    = mem_we_q;
      mem_be_d    = mem_be_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      size_d      = size_q;
      off_d       = off_q;
      ld_signed_d = ld_signed_q;
      store_d     = store_q;
      rdata_d     = rdata_q;
      done_d      = 1'b0;
      exc_valid_d = 1'b0;
      exc_code_d  = 2'b00;

      case (state_q)
         IDLE: begin
            if (req_valid) begin
               if (misaligned) begin
                  exc_valid_d = 1'b1;
                  exc_code_d  = req_we ? 2'b10 : 2'b01;
                  state_d     = ERR;
               end else begin
                  mem_en_d    = 1'b1;
                  mem_we_d    = req_we;
                  mem_be_d    = be_req;
                  mem_addr_d  = {addr[31:2], 2'b00};
                  mem_wdata_d = wdata_rep;
                  size_d      = st_signal;
                  off_d       = addr[1:0];
                  ld_signed_d = ld_signed;
                  store_d     = req_we;
                  wait_cnt_d  = '0;
                  state_d     = ACCESS;
               end
            end
         end
         ACCESS: begin
            // mem_ready takes priority over the timeout in the same cycle.
            if (mem.mem_ready) begin
               rdata_d  = store_q ? '0 : rd_ext;
               mem_en_d = 1'b0;
               mem_we_d = 1'b0;
               done_d   = 1'b1;
               state_d  = DONE;
            end else if (wait_cnt_q == LAST_WAIT) begin
               mem_en_d    = 1'b0;
               mem_we_d    = 1'b0;
               exc_valid_d = 1'b1;
               exc_code_d  = 2'b11;
               state_d     = ERR;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         wait_cnt_q  <= '0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_be_q    <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         size_q      <= '0;
         off_q       <= '0;
         ld_signed_q <= 1'b0;
         store_q     <= 1'b0;
         rdata_q     <= '0;
         done_q      <= 1'b0;
         exc_valid_q <= 1'b0;
         exc_code_q  <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_be_q    <= mem_be_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         size_q      <= size_d;
         off_q       <= off_d;
         ld_signed_q <= ld_signed_d;
         store_q     <= store_d;
         rdata_q     <= rdata_d;
         done_q      <= done_d;
         exc_valid_q <= exc_valid_d;
         exc_code_q  <= exc_code_d;
      end
   end

   // Gated by reset so the pipeline is released while reset is asserted.
   assign stall = !reset && ((state_q == ACCESS) || ((state_q == IDLE) && req_valid));

   assign rdata         = rdata_q;
   assign done          = done_q;
   assign exc_valid     = exc_valid_q;
   assign exc_code      = exc_code_q;
   assign mem.mem_en    = mem_en_q;
   assign mem.mem_we    = mem_we_q;
   assign mem.mem_be    = mem_be_q;
   assign mem.mem_addr  = mem_addr_q;
   assign mem.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// tb_dm_access_ctrl
//   Self-checking bench for dm_access_ctrl with TIMEOUT = 4: a table of
//   directed transactions, a reset-during-access sequence, then random
//   transactions checked against a byte-level reference model.
module tb_dm_access_ctrl;
   localparam int unsigned TO = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_we;
   logic [1:0]  st_signal;
   logic        ld_signed;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        stall;
   logic [31:0] rdata;
   logic        done;
   logic        exc_valid;
   logic [1:0]  exc_code;

   dm_access_ctrl_if mem_bus ();

   dm_access_ctrl #(.TIMEOUT(TO)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_we    (req_we),
      .st_signal (st_signal),
      .ld_signed (ld_signed),
      .addr      (addr),
      .wdata     (wdata),
      .stall     (stall),
      .rdata     (rdata),
      .done      (done),
      .exc_valid (exc_valid),
      .exc_code  (exc_code),
      .mem       (mem_bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        sgn;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rd;
      int unsigned delay;
      logic [3:0]  be;
      logic [31:0] wrep;
      logic [31:0] rdata;
      logic [1:0]  code;
      int unsigned n_stall;
      int unsigned n_en;
   } vec_t;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Reference model: byte-lane arithmetic straight from the access rules.
   function automatic vec_t model(input logic we, input logic [1:0] size, input logic sgn,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  input logic [31:0] rd, input int unsigned delay);
      vec_t v;
      int unsigned nbytes;
      int unsigned off;
      logic [63:0] raw;
      logic [63:0] mask;
      v.we = we; v.size = size; v.sgn = sgn; v.addr = a; v.wdata = wd; v.rd = rd;
      v.delay = delay; v.be = '0; v.wrep = '0; v.rdata = '0;
      nbytes = (size == 2'd3) ? 0 : (1 << size);
      off = a % 4;
      if (nbytes == 0 || (off % nbytes) != 0) begin
         v.code = we ? 2'd2 : 2'd1;
         v.n_stall = 1;
         v.n_en = 0;
      end else begin
         v.be = 4'(((1 << nbytes) - 1) << off);
         for (int i = 0; i < 4; i++) v.wrep[8*i +: 8] = wd[8*(i % nbytes) +: 8];
         if (delay < TO) begin
            v.code = 2'd0;
            v.n_stall = 2 + delay;
            v.n_en = delay + 1;
            if (!we) begin
               raw  = 64'(rd) >> (8 * off);
               mask = (64'd1 << (8 * nbytes)) - 64'd1;
               raw  = raw & mask;
               if (sgn && raw[8*nbytes-1]) raw = raw | ~mask;
               v.rdata = raw[31:0];
            end
         end else begin
            v.code = 2'd3;
            v.n_stall = 1 + TO;
            v.n_en = TO;
         end
      end
      return v;
   endfunction

   // Drives one request, acts as the memory (ready after v.delay wait cycles)
   // and compares everything observed against the record's expectations.
   // Returns in the completion cycle with req_valid still high, so the next
   // call lands on the IDLE cycle right after DONE/ERR.
   task automatic run_vec(input vec_t v, input string tag);
      int unsigned n_stall = 0, n_en = 0, n_done = 0, n_exc = 0;
      int unsigned n_unstable = 0, n_badcode = 0;
      logic [1:0]  got_code = '0;
      logic [31:0] got_rdata = '0, a0 = '0, w0 = '0;
      logic [3:0]  b0 = '0;
      logic        we0 = 1'b0;
      bit          finished = 0;
      @(negedge clk);
      req_valid = 1'b1; req_we = v.we; st_signal = v.size; ld_signed = v.sgn;
      addr = v.addr; wdata = v.wdata;
      mem_bus.mem_ready = 1'b0; mem_bus.mem_rdata = v.rd;
      for (int cyc = 0; cyc < int'(TO) + 8 && !finished; cyc++) begin
         #1;
         if (stall) n_stall++;
         if (!exc_valid && exc_code != 2'b00) n_badcode++;
         mem_bus.mem_ready = 1'b0;
         if (mem_bus.mem_en) begin
            if (n_en == 0) begin
               a0 = mem_bus.mem_addr; b0 = mem_bus.mem_be;
               w0 = mem_bus.mem_wdata; we0 = mem_bus.mem_we;
            end else if (a0 !== mem_bus.mem_addr || b0 !== mem_bus.mem_be ||
                         w0 !== mem_bus.mem_wdata || we0 !== mem_bus.mem_we) begin
               n_unstable++;
            end
            mem_bus.mem_ready = (n_en == v.delay);
            n_en++;
         end
         if (done)      begin n_done++; got_rdata = rdata; finished = 1; end
         if (exc_valid) begin n_exc++;  got_code = exc_code; finished = 1; end
         if (!finished) @(negedge clk);
      end
      mem_bus.mem_ready = 1'b0;
      check({tag, " complete"}, 32'(finished), 32'd1);
      check({tag, " stall_cycles"}, n_stall, v.n_stall);
      check({tag, " en_cycles"}, n_en, v.n_en);
      check({tag, " done_count"}, n_done, (v.code == 2'd0) ? 32'd1 : 32'd0);
      check({tag, " exc_count"}, n_exc, (v.code == 2'd0) ? 32'd0 : 32'd1);
      check({tag, " exc_code"}, 32'(got_code), 32'(v.code));
      check({tag, " code_idle_zero"}, n_badcode, 32'd0);
      if (v.n_en > 0 && n_en > 0) begin
         check({tag, " mem_be"}, 32'(b0), 32'(v.be));
         check({tag, " mem_addr"}, a0, {v.addr[31:2], 2'b00});
         check({tag, " mem_we"}, 32'(we0), 32'(v.we));
         check({tag, " mem_stable"}, n_unstable, 32'd0);
         if (v.we) check({tag, " mem_wdata"}, w0, v.wrep);
      end
      if (n_done > 0 && v.code == 2'd0) check({tag, " rdata"}, got_rdata, v.rdata);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " stall"},     32'(stall), 32'd0);
      check({tag, " mem_en"},    32'(mem_bus.mem_en), 32'd0);
      check({tag, " mem_we"},    32'(mem_bus.mem_we), 32'd0);
      check({tag, " mem_be"},    32'(mem_bus.mem_be), 32'd0);
      check({tag, " mem_addr"},  mem_bus.mem_addr, 32'd0);
      check({tag, " mem_wdata"}, mem_bus.mem_wdata, 32'd0);
      check({tag, " rdata"},     rdata, 32'd0);
      check({tag, " done"},      32'(done), 32'd0);
      check({tag, " exc_valid"}, 32'(exc_valid), 32'd0);
      check({tag, " exc_code"},  32'(exc_code), 32'd0);
   endtask

   vec_t tbl[13];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got simulation still running expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned spurious;
      bit          en_seen;
      vec_t        v;

      //        we    size   sgn   addr          wdata         rd            dly be       wrep          rdata         code  st en
      tbl[0]  = '{1'b1, 2'b00, 1'b0, 32'h0000_1003, 32'h0000_00A5, 32'h0,        0,  4'b1000, 32'hA5A5_A5A5, 32'h0,        2'd0, 2, 1};
      tbl[1]  = '{1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'h0,        32'h8001_1234, 0,  4'b1100, 32'h0,        32'hFFFF_8001, 2'd0, 2, 1};
      tbl[2]  = '{1'b0, 2'b01, 1'b0, 32'h0000_2002, 32'h0,        32'h8001_1234, 0,  4'b1100, 32'h0,        32'h0000_8001, 2'd0, 2, 1};
      tbl[3]  = '{1'b0, 2'b00, 1'b0, 32'h0000_2001, 32'h0,        32'h8001_1234, 0,  4'b0010, 32'h0,        32'h0000_0012, 2'd0, 2, 1};
      tbl[4]  = '{1'b0, 2'b10, 1'b0, 32'h0000_3000, 32'h0,        32'hDEAD_BEEF, 3,  4'b1111, 32'h0,        32'hDEAD_BEEF, 2'd0, 5, 4};
      tbl[5]  = '{1'b1, 2'b10, 1'b0, 32'h0000_4002, 32'h1111_2222, 32'h0,        0,  4'b0000, 32'h0,        32'h0,        2'd2, 1, 0};
      tbl[6]  = '{1'b0, 2'b01, 1'b0, 32'h0000_4001, 32'h0,        32'h0,        0,  4'b0000, 32'h0,        32'h0,        2'd1, 1, 0};
      tbl[7]  = '{1'b0, 2'b11, 1'b0, 32'h0000_0000, 32'h0,        32'h0,        0,  4'b0000, 32'h0,        32'h0,        2'd1, 1, 0};
      tbl[8]  = '{1'b0, 2'b10, 1'b0, 32'h0000_5000, 32'h0,        32'h1234_5678, 99, 4'b1111, 32'h0,        32'h0,        2'd3, 5, 4};
      tbl[9]  = '{1'b1, 2'b00, 1'b0, 32'h0000_6001, 32'h1234_567E, 32'h0,        3,  4'b0010, 32'h7E7E_7E7E, 32'h0,        2'd0, 5, 4};
      tbl[10] = '{1'b1, 2'b01, 1'b0, 32'h0000_6002, 32'hCAFE_BEEF, 32'h0,        1,  4'b1100, 32'hBEEF_BEEF, 32'h0,        2'd0, 3, 2};
      tbl[11] = '{1'b0, 2'b00, 1'b1, 32'h0000_7003, 32'h0,        32'h80FF_0011, 0,  4'b1000, 32'h0,        32'hFFFF_FF80, 2'd0, 2, 1};
      tbl[12] = '{1'b1, 2'b01, 1'b0, 32'h0000_7003, 32'h0,        32'h0,        0,  4'b0000, 32'h0,        32'h0,        2'd2, 1, 0};

      reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; st_signal = 2'b00; ld_signed = 1'b0;
      addr = '0; wdata = '0; mem_bus.mem_rdata = '0; mem_bus.mem_ready = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check_all_zero("reset");
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 13; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

      // Reset in the middle of an ACCESS: everything drops at once.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; st_signal = 2'b10; addr = 32'h0000_8000;
      mem_bus.mem_ready = 1'b0;
      en_seen = 0;
      for (int c = 0; c < 4 && !en_seen; c++) begin
         @(negedge clk);
         #1;
         en_seen = mem_bus.mem_en;
      end
      check("rst_mid pre mem_en", 32'(en_seen), 32'd1);
      #2 reset = 1'b1;
      #1;
      check("rst_mid mem_en", 32'(mem_bus.mem_en), 32'd0);
      check("rst_mid stall", 32'(stall), 32'd0);
      req_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      #1;
      check_all_zero("post_reset");
      spurious = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         #1;
         if (done || exc_valid || mem_bus.mem_en) spurious++;
      end
      check("post_reset abandoned", spurious, 32'd0);
      run_vec(tbl[0], "after_reset");

      for (int i = 0; i < 150; i++) begin
         v = model(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   $urandom, $urandom, $urandom, $urandom_range(0, 5));
         if ($urandom_range(0, 3) == 0) begin
            @(negedge clk);
            req_valid = 1'b0;
         end
         run_vec(v, $sformatf("rnd%0d", i));
      end

      @(negedge clk);
      req_valid = 1'b0;
      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/dm_access_ctrl.md
# dm_access_ctrl

Memory-stage data-memory access controller for the pipelined CPU. Takes one load or store per MEM-stage instruction and sequences it onto a variable-latency data memory with a `mem_ready` handshake. It generates lane byte-enables and replicates store data onto byte lanes. It sign- or zero-extends load data, stalls the pipeline until the access completes, and reports misalignment and bus-timeout exceptions.

## Interface
- `TIMEOUT`, default 15: maximum cycles spent in ACCESS waiting for `mem_ready`; legal range 1..255.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; all state and outputs cleared immediately.
- `req_valid` in 1: MEM-stage instruction is a load or store.
- `req_we` in 1: 1 = store, 0 = load.
- `st_signal` in 2: access size; 00 byte, 01 half, 10 word, 11 illegal (treated as misaligned).
- `ld_signed` in 1: loads only; 1 = sign-extend, 0 = zero-extend.
- `addr` in 32: byte address.
- `wdata` in 32: store data, right-justified.
- `stall` out 1: freeze the PC and the IF/ID/EX/MEM registers.
- `rdata` out 32: extended load result; valid while `done` = 1.
- `done` out 1: one-cycle pulse; the access completed without exception.
- `exc_valid` out 1: one-cycle pulse; an exception occurred.
- `exc_code` out 2: 01 AdEL, 10 AdES, 11 bus timeout; 00 when `exc_valid` = 0.
- `mem_en`, `mem_we` out 1 each: memory request and write strobe.
- `mem_be` out 4: byte-lane enables.
- `mem_addr` out 32: word address, with bits [1:0] = 00.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_rdata` in 32: memory read data.
- `mem_ready` in 1: memory completes the access this cycle.

## Operation
FSM states: IDLE, ACCESS, DONE, ERR.

- **IDLE, `req_valid` = 0:**
  - Stay in IDLE.
  - `stall` = 0.
- **IDLE, `req_valid` = 1, legal request:**
  - Register `mem_addr` = {`addr`[31:2], 00}, `mem_be`, `mem_we` = `req_we`, `mem_wdata`, and the size/offset/`ld_signed` for extension.
  - Set `mem_en` = 1 and go to ACCESS.
  - `stall` = 1 in this cycle.
- **IDLE, `req_valid` = 1, misaligned request:**
  - Misaligned means: half with `addr`[0] = 1, word with `addr`[1:0] != 0, or `st_signal` = 11.
  - No memory access is issued.
  - Latch the exception code: AdES for a store, AdEL for a load.
  - Go to ERR. `stall` = 1 in this cycle.
- **Byte enables:**
  - Word: 1111.
  - Half: offset 0 gives 0011, offset 2 gives 1100.
  - Byte: 0001 << offset.
  - Loads drive the same `mem_be`.
- **Store data replication:**
  - Byte: {4{`wdata`[7:0]}}.
  - Half: {2{`wdata`[15:0]}}.
  - Word: `wdata` unchanged.
- **ACCESS:**
  - `stall` = 1; memory outputs are held stable.
  - The wait counter clears on entry and increments on each ACCESS cycle without `mem_ready`.
  - `mem_ready` = 1: capture `mem_rdata`, deassert `mem_en`, go to DONE.
  - `mem_ready` = 0 and counter = `TIMEOUT`-1: deassert `mem_en`, latch code 11, go to ERR.
  - If `mem_ready` = 1 in the timeout cycle, `mem_ready` wins.
- **Load extension:**
  - Select the byte or halfword lane from the latched offset, then extend per the latched `ld_signed`.
  - Word loads pass through unchanged.
  - For stores, `rdata` = 0.
- **DONE:**
  - `done` = 1, `stall` = 0, `rdata` valid.
  - Next state is IDLE unconditionally. `req_valid` in this cycle belongs to the completing instruction and is ignored.
- **ERR:**
  - `exc_valid` = 1, `exc_code` = latched code, `stall` = 0.
  - Next state is IDLE.

## Timing
- **Reset values:**
  - State = IDLE.
  - `mem_en`, `mem_we`, `done`, `exc_valid` = 0.
  - `mem_be` = 0000; `mem_addr`, `mem_wdata`, `rdata` = 0; `exc_code` = 00.
- **`stall`:** combinational from state and `req_valid`. It is 0 while `reset` is high.
- **Registered outputs:** all memory-side outputs, `done`, `exc_valid`, `exc_code` and `rdata` are registered.
- **Minimum latency:** request seen in IDLE at cycle 0; `mem_en` high from cycle 1; `mem_ready` in cycle 1; `done` in cycle 2. `stall` is high for cycles 0–1, so there are 2 stall cycles.
- **With n wait cycles:** `stall` is high for 2+n cycles.
- **Timeout:** `mem_en` stays high for exactly `TIMEOUT` cycles, then `exc_valid` pulses.
- **Misalignment:** 1 stall cycle, then the `exc_valid` pulse; `mem_en` is never asserted.
- **Reset mid-ACCESS:** `mem_en` drops asynchronously. The pending access is abandoned, with no `done` and no exception.
- **Back-to-back:** a new request is accepted in the IDLE cycle immediately after DONE or ERR.

## Test plan
- **Reset:** assert `reset` during ACCESS → `mem_en` = 0 and `stall` = 0 within the same cycle. After release, the FSM is in IDLE and all outputs are 0.
- **Store byte:** `addr` = 0x0000_1003, `st_signal` = 00, `wdata` = 0x0000_00A5, `mem_ready` in the first ACCESS cycle → `mem_be` = 1000, `mem_wdata` = 0xA5A5_A5A5, `mem_addr` = 0x0000_1000, `stall` high 2 cycles, then `done`.
- **Load half, signed:** `addr` = 0x...2, `mem_rdata` = 0x8001_1234, `ld_signed` = 1 → `rdata` = 0xFFFF_8001. Same with `ld_signed` = 0 → 0x0000_8001. Byte load at offset 1 → 0x0000_0012 (zero-extended).
- **Wait states:** `mem_ready` delayed 3 cycles → `stall` high 5 cycles, memory outputs constant throughout, `done` a single pulse.
- **Misaligned:** word store at 0x...2 → `exc_code` = 10 and `exc_valid` pulse after 1 stall cycle, `mem_en` never high. Half load at 0x...1 → `exc_code` = 01.
- **Timeout:** `TIMEOUT` = 4, `mem_ready` held low → `mem_en` high for exactly 4 cycles, then `exc_code` = 11. Repeat with `mem_ready` = 1 in the 4th cycle → `done`, no exception.
